// File: rtl/irq_mmio_ctrl_if.sv
// Data-memory bus between the MIPS core (master) and the interrupt controller (slave).
// No FSM in this block; the bus carries single-cycle strobes only.
interface irq_mmio_ctrl_if;
  // Handshake: memread/memwrite are one-cycle strobes qualified by dataadr, with no ready/stall.
  // A read hit at edge K loads readdata and raises rdvalid for exactly the cycle after K.
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rdvalid;

  modport master (
    output memwrite, memread, dataadr, writedata,
    input  readdata, rdvalid
  );

  modport slave (
    input  memwrite, memread, dataadr, writedata,
    output readdata, rdvalid
  );
endinterface

// File: rtl/irq_mmio_ctrl.sv
// Memory-mapped interrupt controller: synchronise, edge-detect and latch irq_in, mask into cpu_int.
// Optional macro IRQ_MMIO_COUNT_EN adds per-line 8-bit saturating rise counters at 0x10/0x14.
module irq_mmio_ctrl #(
  parameter logic [31:0] BASE        = 32'hBFFF0000,
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               ph1,
  input  logic               reset_b,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_mmio_ctrl_if.slave     bus,
  output logic [NUM_IRQ-1:0] cpu_int,
  output logic               int_any
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c_bits;
  logic [NUM_IRQ-1:0] force_bits;
  logic [31:0]        rd_word;
  logic [31:0]        cnt_lo;
  logic [31:0]        cnt_hi;
  logic               hit;
  logic               wr_en;
  logic               rd_en;
  logic [2:0]         off;
  logic               unused_bits;

  assign hit   = (bus.dataadr[31:5] == BASE[31:5]);
  assign off   = bus.dataadr[4:2];
  assign wr_en = bus.memwrite & hit;
  assign rd_en = bus.memread & hit;

  assign unused_bits = ^{bus.dataadr[1:0], bus.writedata[31:NUM_IRQ]};

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    w1c_bits   = '0;
    force_bits = '0;
    if (wr_en && off == 3'd0) w1c_bits   = bus.writedata[NUM_IRQ-1:0];
    if (wr_en && off == 3'd3) force_bits = bus.writedata[NUM_IRQ-1:0];
  end

  // Clear first, then set: a rise landing on the same edge as a W1C keeps the bit.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= (pending_q & ~w1c_bits) | rise | force_bits;
      if (wr_en && off == 3'd1) mask_q <= bus.writedata[NUM_IRQ-1:0];
    end
  end

`ifdef IRQ_MMIO_COUNT_EN
  logic [7:0]  cnt_q [NUM_IRQ];
  logic        cnt_clr;
  logic [63:0] cnt_flat;

  assign cnt_clr = wr_en && (off == 3'd4 || off == 3'd5);

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_IRQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cnt_clr)
          cnt_q[i] <= {7'd0, rise[i]};
        else if (rise[i] && cnt_q[i] != 8'hFF)
          cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_IRQ; i++) cnt_flat[8*i +: 8] = cnt_q[i];
  end

  assign cnt_lo = cnt_flat[31:0];
  assign cnt_hi = cnt_flat[63:32];
`else
  assign cnt_lo = '0;
  assign cnt_hi = '0;
`endif

  always_comb begin
    rd_word = '0;
    case (off)
      3'd0:    rd_word[NUM_IRQ-1:0] = pending_q;
      3'd1:    rd_word[NUM_IRQ-1:0] = mask_q;
      3'd2:    rd_word[NUM_IRQ-1:0] = pending_q & mask_q;
      3'd4:    rd_word = cnt_lo;
      3'd5:    rd_word = cnt_hi;
      default: rd_word = '0;
    endcase
  end

  // Reads capture pre-edge contents, so a simultaneous write is not visible in this read.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      bus.readdata <= '0;
      bus.rdvalid  <= 1'b0;
    end else begin
      if (rd_en) bus.readdata <= rd_word;
      bus.rdvalid <= rd_en;
    end
  end

  assign cpu_int = pending_q & mask_q;
  assign int_any = |cpu_int;

endmodule

// File: tb/tb_irq_mmio_ctrl.sv
// Bench for irq_mmio_ctrl: register table, directed corner sequences, random traffic vs reference model.
module tb_irq_mmio_ctrl;
  localparam logic [31:0] BASE = 32'hBFFF0000;
  localparam int N = 8;
  localparam int S = 2;

  localparam logic [31:0] A_PEND  = BASE + 32'h00;
  localparam logic [31:0] A_MASK  = BASE + 32'h04;
  localparam logic [31:0] A_ACT   = BASE + 32'h08;
  localparam logic [31:0] A_FORCE = BASE + 32'h0C;
  localparam logic [31:0] A_CNT0  = BASE + 32'h10;
  localparam logic [31:0] A_CNT1  = BASE + 32'h14;

  logic         ph1 = 1'b0;
  logic         reset_b = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] cpu_int;
  logic         int_any;

  irq_mmio_ctrl_if bus ();

  irq_mmio_ctrl #(.BASE(BASE), .NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .ph1     (ph1),
    .reset_b (reset_b),
    .irq_in  (irq_in),
    .bus     (bus),
    .cpu_int (cpu_int),
    .int_any (int_any)
  );

  // ---------------- clock / reset ----------------
  always #5 ph1 = ~ph1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Register-level view: rise = sampled input high now-S edges ago and low the edge before that.
  logic [N-1:0]  m_pend, m_mask;
  logic [7:0]    m_cnt [N];
  logic [31:0]   m_rd;
  logic          m_rdv;
  logic [N-1:0]  m_samp [$];
  logic [N-1:0]  m_rise;
  logic [N-1:0]  m_wd;
  logic          m_hit, m_clr;
  int            m_off;

  function automatic logic [31:0] m_reg(input int o);
    logic [31:0] r;
    r = '0;
    case (o)
      0: r[N-1:0] = m_pend;
      1: r[N-1:0] = m_mask;
      2: r[N-1:0] = m_pend & m_mask;
`ifdef IRQ_MMIO_COUNT_EN
      4: for (int i = 0; i < 4; i++) r[8*i +: 8] = m_cnt[i];
      5: for (int i = 0; i < 4; i++) r[8*i +: 8] = m_cnt[i+4];
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      m_pend = '0;
      m_mask = '0;
      m_rd   = '0;
      m_rdv  = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      m_samp = {};
      for (int i = 0; i < S + 2; i++) m_samp.push_front('0);
    end else begin
      m_hit = (bus.dataadr[31:5] == BASE[31:5]);
      m_off = int'(bus.dataadr[4:2]);
      m_wd  = bus.writedata[N-1:0];
      if (bus.memread && m_hit) begin
        m_rd  = m_reg(m_off);
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      m_samp.push_front(irq_in);
      void'(m_samp.pop_back());
      m_rise = m_samp[S] & ~m_samp[S+1];
      m_clr = 1'b0;
      if (bus.memwrite && m_hit) begin
        case (m_off)
          0: m_pend = m_pend & ~m_wd;
          1: m_mask = m_wd;
          3: m_pend = m_pend | m_wd;
          4, 5: m_clr = 1'b1;
          default: ;
        endcase
      end
      m_pend = m_pend | m_rise;
      for (int i = 0; i < N; i++) begin
`ifdef IRQ_MMIO_COUNT_EN
        if (m_clr) m_cnt[i] = m_rise[i] ? 8'd1 : 8'd0;
        else if (m_rise[i] && m_cnt[i] != 8'd255) m_cnt[i] = m_cnt[i] + 8'd1;
`else
        m_cnt[i] = '0;
`endif
      end
    end
  end

  // Continuous comparison of every output against the model, mid-cycle.
  always @(negedge ph1) begin
    if (reset_b) begin
      check("cpu_int",  {24'd0, cpu_int}, {24'd0, m_pend & m_mask});
      check("int_any",  {31'd0, int_any}, {31'd0, |(m_pend & m_mask)});
      check("rdvalid",  {31'd0, bus.rdvalid}, {31'd0, m_rdv});
      check("readdata", bus.readdata, m_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] adr, input logic [31:0] data);
    @(negedge ph1);
    bus.memwrite  = 1'b1;
    bus.memread   = 1'b0;
    bus.dataadr   = adr;
    bus.writedata = data;
    @(negedge ph1);
    bus.memwrite  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] adr, output logic [31:0] data, output logic valid);
    @(negedge ph1);
    bus.memread  = 1'b1;
    bus.memwrite = 1'b0;
    bus.dataadr  = adr;
    @(negedge ph1);
    data  = bus.readdata;
    valid = bus.rdvalid;
    bus.memread = 1'b0;
  endtask

  task automatic pulse(input int line, input int cycles);
    @(negedge ph1);
    irq_in[line] = 1'b1;
    repeat (cycles) @(negedge ph1);
    irq_in[line] = 1'b0;
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_v;
  } vec_t;

  vec_t tbl [23];

  initial begin
    logic [31:0] rd;
    logic        rv;

    tbl[0]  = '{1'b0, A_MASK,           32'h0,        32'h0,  1'b1};
    tbl[1]  = '{1'b0, A_PEND,           32'h0,        32'h0,  1'b1};
    tbl[2]  = '{1'b0, A_ACT,            32'h0,        32'h0,  1'b1};
    tbl[3]  = '{1'b1, A_MASK,           32'h3,        32'h0,  1'b0};
    tbl[4]  = '{1'b0, A_MASK,           32'h0,        32'h3,  1'b1};
    tbl[5]  = '{1'b1, A_FORCE,          32'h80,       32'h0,  1'b0};
    tbl[6]  = '{1'b0, A_PEND,           32'h0,        32'h80, 1'b1};
    tbl[7]  = '{1'b0, A_ACT,            32'h0,        32'h0,  1'b1};
    tbl[8]  = '{1'b0, A_FORCE,          32'h0,        32'h0,  1'b1};
    tbl[9]  = '{1'b0, BASE + 32'h1C,    32'h0,        32'h0,  1'b1};
    tbl[10] = '{1'b1, A_ACT,            32'hFF,       32'h0,  1'b0};
    tbl[11] = '{1'b0, A_ACT,            32'h0,        32'h0,  1'b1};
    tbl[12] = '{1'b1, A_MASK,           32'hFFFFFFFF, 32'h0,  1'b0};
    tbl[13] = '{1'b0, A_MASK,           32'h0,        32'hFF, 1'b1};
    tbl[14] = '{1'b0, A_ACT,            32'h0,        32'h80, 1'b1};
    tbl[15] = '{1'b1, A_PEND,           32'hFFFFFFFF, 32'h0,  1'b0};
    tbl[16] = '{1'b0, A_PEND,           32'h0,        32'h0,  1'b1};
    tbl[17] = '{1'b1, A_MASK,           32'h5A,       32'h0,  1'b0};
    tbl[18] = '{1'b0, BASE + 32'h07,    32'h0,        32'h5A, 1'b1};
    tbl[19] = '{1'b0, BASE + 32'h20,    32'h0,        32'h5A, 1'b0};
    tbl[20] = '{1'b0, 32'h0000_0004,    32'h0,        32'h5A, 1'b0};
    tbl[21] = '{1'b0, A_CNT0,           32'h0,        32'h0,  1'b1};
    tbl[22] = '{1'b1, A_MASK,           32'h0,        32'h0,  1'b0};

    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;

    // Reset state
    repeat (3) @(negedge ph1);
    check("rst_cpu_int",  {24'd0, cpu_int}, 32'h0);
    check("rst_int_any",  {31'd0, int_any}, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_rdvalid",  {31'd0, bus.rdvalid}, 32'h0);
    reset_b = 1'b1;

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].adr, tbl[i].data);
      end else begin
        bus_read(tbl[i].adr, rd, rv);
        check($sformatf("tbl%0d_valid", i), {31'd0, rv}, {31'd0, tbl[i].exp_v});
        check($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
      end
    end

    // Simultaneous read and write: read returns pre-write contents
    bus_write(A_MASK, 32'h11);
    @(negedge ph1);
    bus.memread = 1'b1; bus.memwrite = 1'b1; bus.dataadr = A_MASK; bus.writedata = 32'h22;
    @(negedge ph1);
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    check("rw_same_edge_data", bus.readdata, 32'h11);
    bus_read(A_MASK, rd, rv);
    check("rw_mask_after", rd, 32'h22);

    // Latency: set exactly S edges after first sample, W1C drops cpu_int next cycle
    bus_write(A_MASK, 32'h03);
    @(negedge ph1);
    irq_in[1] = 1'b1;
    @(negedge ph1);
    check("lat_edge_n", {24'd0, cpu_int}, 32'h0);
    @(negedge ph1);
    check("lat_edge_n1", {24'd0, cpu_int}, 32'h0);
    @(negedge ph1);
    check("lat_edge_n2", {24'd0, cpu_int}, 32'h02);
    repeat (2) @(negedge ph1);
    irq_in[1] = 1'b0;
    bus_read(A_PEND, rd, rv);
    check("lat_pend", rd, 32'h02);
    bus_write(A_PEND, 32'h02);
    check("w1c_next_cycle", {24'd0, cpu_int}, 32'h0);

    // Masked pending stays latched; unmask asserts immediately
    bus_write(A_MASK, 32'h00);
    pulse(0, 5);
    repeat (3) @(negedge ph1);
    bus_read(A_PEND, rd, rv);
    check("masked_pend", rd, 32'h01);
    check("masked_cpu_int", {24'd0, cpu_int}, 32'h0);
    bus_write(A_MASK, 32'h01);
    check("unmask_cpu_int", {24'd0, cpu_int}, 32'h01);
    check("unmask_int_any", {31'd0, int_any}, 32'h1);
    bus_write(A_PEND, 32'h01);

    // Held level: rise coincides with W1C -> set wins; steady high never re-sets
    bus_write(A_MASK, 32'hFF);
    bus_write(A_FORCE, 32'h02);
    @(negedge ph1);
    irq_in[1] = 1'b1;
    @(negedge ph1);
    @(negedge ph1);
    bus.memwrite = 1'b1; bus.dataadr = A_PEND; bus.writedata = 32'h02;
    @(negedge ph1);
    bus.memwrite = 1'b0;
    check("set_wins_w1c", {31'd0, cpu_int[1]}, 32'h1);
    bus_write(A_PEND, 32'h02);
    repeat (80) @(negedge ph1);
    check("held_no_reset", {24'd0, cpu_int}, 32'h0);
    irq_in[1] = 1'b0;
    repeat (4) @(negedge ph1);

    // Asynchronous reset mid-access
    bus_write(A_FORCE, 32'h80);
    check("force_cpu_int", {24'd0, cpu_int}, 32'h80);
    bus_read(A_PEND, rd, rv);
    check("force_pend", rd, 32'h80);
    @(negedge ph1);
    bus.memread = 1'b1; bus.dataadr = A_MASK;
    @(posedge ph1);
    #2;
    reset_b = 1'b0;
    #1;
    check("arst_cpu_int",  {24'd0, cpu_int}, 32'h0);
    check("arst_int_any",  {31'd0, int_any}, 32'h0);
    check("arst_readdata", bus.readdata, 32'h0);
    check("arst_rdvalid",  {31'd0, bus.rdvalid}, 32'h0);
    bus.memread = 1'b0;
    @(negedge ph1);
    @(negedge ph1);
    reset_b = 1'b1;
    bus_read(A_MASK, rd, rv);
    check("post_rst_mask", rd, 32'h0);

    // Counter saturation and clear
    repeat (300) pulse(2, 1);
    repeat (4) @(negedge ph1);
    bus_read(A_PEND, rd, rv);
    check("cnt_pend", rd, 32'h04);
`ifdef IRQ_MMIO_COUNT_EN
    bus_read(A_CNT0, rd, rv);
    check("cnt_sat", rd, 32'h00FF0000);
`else
    bus_read(A_CNT0, rd, rv);
    check("cnt_absent", rd, 32'h0);
`endif
    bus_read(A_CNT1, rd, rv);
    check("cnt_hi", rd, 32'h0);
    bus_write(A_CNT0, 32'h0);
    bus_read(A_CNT0, rd, rv);
    check("cnt_clear", rd, 32'h0);

    // Random traffic checked against the model every cycle
    repeat (2000) begin
      int r;
      @(negedge ph1);
      if ($urandom_range(0, 5) == 0) irq_in = irq_in ^ N'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      bus.memwrite = (r < 3) || (r == 9);
      bus.memread  = (r >= 3 && r < 7) || (r == 9);
      if ($urandom_range(0, 7) == 0)
        bus.dataadr = $urandom;
      else
        bus.dataadr = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      bus.writedata = $urandom;
    end
    @(negedge ph1);
    bus.memwrite = 1'b0;
    bus.memread  = 1'b0;
    irq_in = '0;
    repeat (5) @(negedge ph1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
